// File: rtl/mem_copy_engine.sv
// Block-copy initiator: streams `length` words from src_base to dst_base, one per clock.
// Latency L+2 cycles start-to-done; start is ignored unless IDLE, and illegal requests finish immediately with err.
module mem_copy_engine #(
  parameter int data_width = 32,
  parameter int addr_width = 16,
  parameter int depth      = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [addr_width-1:0] src_base,
  input  logic [addr_width-1:0] dst_base,
  input  logic [7:0]            length,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [addr_width-1:0] mem_read_address,
  input  logic [data_width-1:0] mem_read_data,
  output logic [addr_width-1:0] mem_write_address,
  output logic [data_width-1:0] mem_write_data,
  output logic                  mem_WE
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
  localparam int aw1 = addr_width + 1;

  state_t                state;
  logic [7:0]            len_q;
  logic [7:0]            rd_cnt;
  logic [7:0]            wr_cnt;
  logic [addr_width-1:0] dst_q;

  logic [aw1-1:0] src_ext, dst_ext, len_ext, src_end, dst_end;
  logic           illegal;

  // One extra bit on the address sums so an overflowing block is seen as out of range.
  always_comb begin
    src_ext = {1'b0, src_base};
    dst_ext = {1'b0, dst_base};
    len_ext = aw1'(length);
    src_end = src_ext + len_ext;
    dst_end = dst_ext + len_ext;
    illegal = (length == 8'd0) || (len_ext > aw1'(depth)) ||
              (src_end > aw1'(depth)) || (dst_end > aw1'(depth)) ||
              ((src_ext < dst_ext) && (dst_ext < src_end));
  end

  assign mem_write_data = mem_read_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      mem_WE            <= 1'b0;
      mem_read_address  <= '0;
      mem_write_address <= '0;
      len_q             <= '0;
      rd_cnt            <= '0;
      wr_cnt            <= '0;
      dst_q             <= '0;
    end else begin
      // Read data for word k arrives one edge after its address, so writes trail reads by one.
      if (state == RUN || state == DRAIN) begin
        if (wr_cnt != len_q) begin
          mem_WE            <= 1'b1;
          mem_write_address <= dst_q + addr_width'(wr_cnt);
          wr_cnt            <= wr_cnt + 8'd1;
        end else begin
          mem_WE <= 1'b0;
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            if (illegal) begin
              state <= FIN;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state            <= (length == 8'd1) ? DRAIN : RUN;
              busy             <= 1'b1;
              mem_read_address <= src_base;
              len_q            <= length;
              dst_q            <= dst_base;
              rd_cnt           <= '0;
              wr_cnt           <= '0;
            end
          end
        end
        RUN: begin
          mem_read_address <= mem_read_address + addr_width'(1);
          rd_cnt           <= rd_cnt + 8'd1;
          if (rd_cnt + 8'd2 == len_q) state <= DRAIN;
        end
        DRAIN: begin
          if (wr_cnt == len_q) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        FIN: begin
          done  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Randomized bench for mem_copy_engine against a word-array reference of the copy semantics.
module tb_mem_copy_engine;
  localparam int DEPTH = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] src_base = '0;
  logic [15:0] dst_base = '0;
  logic [7:0]  length = '0;
  logic        busy, done, err, mem_WE;
  logic [15:0] mem_read_address, mem_write_address;
  logic [31:0] mem_read_data = '0;
  logic [31:0] mem_write_data;

  logic [31:0] mem [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];
  bit          preloaded = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  mem_copy_engine #(.data_width(32), .addr_width(16), .depth(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_base(src_base), .dst_base(dst_base), .length(length),
    .busy(busy), .done(done), .err(err),
    .mem_read_address(mem_read_address), .mem_read_data(mem_read_data),
    .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
    .mem_WE(mem_WE)
  );

  // Synchronous-read memory with a write port.
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'(i + 100);
      preloaded <= 1'b1;
    end else begin
      mem_read_data <= (int'(mem_read_address) < DEPTH) ? mem[mem_read_address[6:0]] : '0;
      if (mem_WE && int'(mem_write_address) < DEPTH) mem[mem_write_address[6:0]] <= mem_write_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input string tag);
    int nbad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) nbad++;
    chk(tag, nbad, 0);
  endtask

  task automatic do_copy(input int s, input int d, input int l, input bit extra);
    bit legal;
    bit seen_done = 1'b0;
    bit seen_err = 1'b0;
    int cyc = 1;
    int nbusy = 0;
    int nwe = 0;
    int quiet_viol = 0;
    legal = !(l == 0 || l > DEPTH || s + l > DEPTH || d + l > DEPTH || (s < d && d < s + l));
    if (legal) for (int k = 0; k < l; k++) ref_mem[d + k] = ref_mem[s + k];
    @(negedge clk);
    start = 1'b1; src_base = 16'(s); dst_base = 16'(d); length = 8'(l);
    @(negedge clk);
    start = 1'b0;
    src_base = 16'($urandom_range(0, 127)); dst_base = 16'($urandom_range(0, 127));
    length = 8'($urandom_range(1, 20));
    while (cyc <= 300) begin
      if (busy) nbusy++;
      if (mem_WE) nwe++;
      if (done) begin
        seen_done = 1'b1;
        seen_err  = err;
        break;
      end
      start = extra && (cyc == 1);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", 32'(seen_done), 1);
    chk("latency", cyc, legal ? l + 2 : 1);
    chk("err", 32'(seen_err), legal ? 0 : 1);
    chk("busy_cycles", nbusy, legal ? l + 1 : 0);
    chk("we_cycles", nwe, legal ? l : 0);
    for (int q = 0; q < 3; q++) begin
      @(negedge clk);
      if (busy || done || err || mem_WE) quiet_viol++;
    end
    chk("idle_quiet", quiet_viol, 0);
    chk_mem("mem_contents");
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'(i + 100);
    #12;
    chk("reset_flags", {28'd0, busy, done, err, mem_WE}, 0);
    chk("reset_raddr", 32'(mem_read_address), 0);
    chk("reset_waddr", 32'(mem_write_address), 0);
    @(negedge clk);
    rst = 1'b1;

    do_copy(0, 64, 16, 1'b0);
    chk("mem80_untouched", mem[80], 180);
    do_copy(10, 8, 5, 1'b0);
    do_copy(4, 6, 4, 1'b0);
    do_copy(0, 0, 0, 1'b0);
    do_copy(0, 0, 129, 1'b0);
    do_copy(120, 0, 10, 1'b0);
    do_copy(127, 0, 1, 1'b1);
    chk("mem0_single", mem[0], 227);

    // Mid-copy reset: words 0..7 have committed by the time rst falls in cycle 10.
    for (int k = 0; k < 8; k++) ref_mem[64 + k] = ref_mem[k];
    @(negedge clk);
    start = 1'b1; src_base = 16'd0; dst_base = 16'd64; length = 8'd32;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("async_rst_flags", {28'd0, busy, done, err, mem_WE}, 0);
    chk("async_rst_raddr", 32'(mem_read_address), 0);
    chk("async_rst_waddr", 32'(mem_write_address), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_mem("partial_copy");
    do_copy(0, 64, 32, 1'b0);

    for (int n = 0; n < 20; n++) begin
      int l, s, d;
      l = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 140)) : int'($urandom_range(1, 40));
      s = $urandom_range(0, 100);
      d = $urandom_range(0, 100);
      do_copy(s, d, l, n[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
